// File: rtl/wb_rr_arbiter2_pkg.sv
// Shared definitions for the two-master Wishbone round-robin arbiter:
// FSM state encodings, default bus widths and the state-to-grant decode.
package wb_rr_arbiter2_pkg;

  localparam int WB_AW = 8;
  localparam int WB_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_G0   = 2'd1,
    ST_G1   = 2'd2
  } state_t;

  function automatic logic [1:0] state_gnt(input state_t s);
    case (s)
      ST_G0:   return 2'b01;
      ST_G1:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/wb_bus_wdt.sv
// Bus watchdog: counts stalled strobe cycles and fires combinationally when the
// count reaches LIMIT; clears on clr or on its own fire.
module wb_bus_wdt #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk50,
  input  logic arst_n,
  input  logic en,
  input  logic clr,
  output logic fire
);

  localparam logic [7:0] LIM = 8'(LIMIT);

  logic [7:0] cnt;

  assign fire = (cnt == LIM);

  always_ff @(posedge clk50 or negedge arst_n) begin
    if (!arst_n) begin
      cnt <= 8'd0;
    end else if (clr || fire) begin
      cnt <= 8'd0;
    end else if (en) begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/wb_rr_arbiter2.sv
// Two-master, one-slave Wishbone classic round-robin arbiter with bus watchdog.
// Grant is held until the owner drops cyc; every handover passes through IDLE.
module wb_rr_arbiter2
  import wb_rr_arbiter2_pkg::*;
#(
  parameter int          AW      = WB_AW,
  parameter int          DW      = WB_DW,
  parameter int          SW      = DW / 8,
  parameter int unsigned TMO_CYC = 255
) (
  input  logic          clk50,
  input  logic          arst_n,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [DW-1:0] m0_dat_i,
  input  logic [SW-1:0] m0_sel_i,
  output logic [DW-1:0] m0_dat_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [DW-1:0] m1_dat_i,
  input  logic [SW-1:0] m1_sel_i,
  output logic [DW-1:0] m1_dat_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [AW-1:0] s_adr_o,
  output logic [DW-1:0] s_dat_o,
  output logic [SW-1:0] s_sel_o,
  input  logic [DW-1:0] s_dat_i,
  input  logic          s_ack_i,
  input  logic          s_err_i,
  output logic [1:0]    gnt_o,
  output logic          tmo_o
);

  state_t state, state_nxt;
  logic   last, last_nxt;
  logic   stb_raw;
  logic   tmo_fire;

  always_ff @(posedge clk50 or negedge arst_n) begin
    if (!arst_n) begin
      state <= ST_IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  // On a tie the master that did not own the bus last time wins.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_nxt = last ? ST_G0 : ST_G1;
        else if (m0_cyc_i)        state_nxt = ST_G0;
        else if (m1_cyc_i)        state_nxt = ST_G1;
      end
      ST_G0: begin
        if (!m0_cyc_i) begin
          state_nxt = ST_IDLE;
          last_nxt  = 1'b0;
        end
      end
      ST_G1: begin
        if (!m1_cyc_i) begin
          state_nxt = ST_IDLE;
          last_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt_o    = state_gnt(state);
    s_cyc_o  = 1'b0;
    stb_raw  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    case (state)
      ST_G0: begin
        s_cyc_o  = m0_cyc_i;
        stb_raw  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i | tmo_fire;
      end
      ST_G1: begin
        s_cyc_o  = m1_cyc_i;
        stb_raw  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i | tmo_fire;
      end
      default: ;
    endcase
  end

  assign s_stb_o  = stb_raw & ~tmo_fire;
  assign tmo_o    = tmo_fire;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  // Dropping s_cyc_o covers both IDLE and leaving a grant.
  wb_bus_wdt #(.LIMIT(TMO_CYC)) u_wdt (
    .clk50  (clk50),
    .arst_n (arst_n),
    .en     (s_cyc_o & stb_raw & ~s_ack_i & ~s_err_i),
    .clr    (~s_cyc_o | s_ack_i | s_err_i),
    .fire   (tmo_fire)
  );

endmodule
